// File: rtl/max_sort_stream.sv
// Frame sorter: buffers M words, then repeatedly selects the largest remaining word
// with an MSB-first bit-column scan and streams it out with its index and a last flag.
module max_sort_stream #(
    parameter  int M  = 8,
    parameter  int N  = 8,
    localparam int IW = $clog2(M)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_data,
    output logic [IW-1:0] o_idx,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last,
    output logic          o_busy
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_EMIT} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [N-1:0]    r_mem [M];
    logic [IW-1:0]   r_wr_ptr;
    logic [IW-1:0]   r_sel;
    logic [N-1:0]    r_out_data;
    logic [BW-1:0]   r_bit;
    logic [M-1:0]    r_done;
    logic [M-1:0]    r_cand;
    logic [M-1:0]    w_col;
    logic [M-1:0]    w_hit;
    logic [M-1:0]    w_cand_nx;
    logic [M-1:0]    w_done_nx;
    logic [IW-1:0]   w_sel;
    logic [IW:0]     w_done_cnt;
    logic            w_load_fire;
    logic            w_emit_fire;
    logic            w_last;

    // Current bit column across all stored words.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_col
            assign w_col[gi] = r_mem[gi][r_bit];
        end
    endgenerate

    always_comb begin
        w_hit      = r_cand & w_col;
        w_cand_nx  = (|w_hit) ? w_hit : r_cand;
        w_sel      = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (w_cand_nx[k]) w_sel = IW'(k);
        end
        w_done_cnt = '0;
        for (int k = 0; k < M; k++) begin
            w_done_cnt = w_done_cnt + (IW+1)'(r_done[k]);
        end
        w_done_nx  = r_done | (M'(1) << r_sel);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_LOAD;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        w_last      = 1'b0;
        w_load_fire = 1'b0;
        w_emit_fire = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_ready     = 1'b1;
                w_load_fire = i_valid;
                if (i_valid && (r_wr_ptr == IW'(M - 1))) w_state_nx = S_SEARCH;
            end
            S_SEARCH: begin
                o_busy = 1'b1;
                if (r_bit == '0) w_state_nx = S_EMIT;
            end
            S_EMIT: begin
                o_busy      = 1'b1;
                o_valid     = 1'b1;
                w_last      = (w_done_cnt == (IW+1)'(M - 1));
                w_emit_fire = i_ready;
                if (i_ready) w_state_nx = w_last ? S_LOAD : S_SEARCH;
            end
            default: w_state_nx = S_LOAD;
        endcase
    end

    assign o_last = w_last;
    assign o_data = r_out_data;
    assign o_idx  = r_sel;

    // Word storage is never reset: a new frame always overwrites every entry before use.
    always_ff @(posedge i_clk) begin
        if (w_load_fire) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_done     <= '0;
            r_cand     <= '0;
            r_bit      <= '0;
            r_sel      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_fire) begin
                        if (r_wr_ptr == IW'(M - 1)) begin
                            r_wr_ptr <= '0;
                            r_done   <= '0;
                            r_cand   <= '1;
                            r_bit    <= BW'(N - 1);
                        end else begin
                            r_wr_ptr <= r_wr_ptr + IW'(1);
                        end
                    end
                end
                S_SEARCH: begin
                    r_cand <= w_cand_nx;
                    if (r_bit == '0) begin
                        r_sel      <= w_sel;
                        r_out_data <= r_mem[w_sel];
                    end else begin
                        r_bit <= r_bit - BW'(1);
                    end
                end
                S_EMIT: begin
                    // Next pass starts from every word not yet emitted.
                    if (w_emit_fire) begin
                        r_done <= w_done_nx;
                        r_cand <= ~w_done_nx;
                        r_bit  <= BW'(N - 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max_sort_stream.sv
// Scoreboard bench for max_sort_stream (M=4, N=4): directed frames, backpressure,
// mid-frame reset and randomized frames checked against a stable descending sort.
module tb_max_sort_stream;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef logic [N-1:0] frame_t [M];
    typedef struct packed {
        logic [N-1:0]  d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [N-1:0]  o_data;
    logic [IW-1:0] o_idx;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_last;
    logic          o_busy;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pops  = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;      // 0: always ready, 1: random, 2: manual
    logic rdy_manual = 1'b1;
    int   last_hs_cyc = 0;

    max_sort_stream #(.M(M), .N(N)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_idx  (o_idx),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last (o_last),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      i_ready = 1'b1;
        else if (rdy_mode == 1) i_ready = ($urandom_range(0, 3) != 0);
        else                    i_ready = rdy_manual;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output handshake is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", int'(o_data), int'(e.d));
                check("out_idx",  int'(o_idx),  int'(e.i));
                check("out_last", int'(o_last), int'(e.l));
                $display("[TB] out data=%0d idx=%0d last=%0d", o_data, o_idx, o_last);
            end
            n_pops++;
        end
    end

    // Reference: stable descending sort of the frame by value.
    task automatic push_model(input frame_t w);
        int   ord [M];
        int   t;
        exp_t e;
        for (int k = 0; k < M; k++) ord[k] = k;
        for (int a = 1; a < M; a++) begin
            for (int b = a; b > 0; b--) begin
                if (w[ord[b-1]] < w[ord[b]]) begin
                    t = ord[b]; ord[b] = ord[b-1]; ord[b-1] = t;
                end
            end
        end
        for (int k = 0; k < M; k++) begin
            e.d = w[ord[k]];
            e.i = IW'(ord[k]);
            e.l = (k == M - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [N-1:0] d, input int gap);
        logic acc;
        int   hcyc;
        int   guard;
        i_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        i_data  = d;
        i_valid = 1'b1;
        guard   = 0;
        forever begin
            @(negedge clk);
            acc  = o_ready;
            hcyc = cyc;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 500) begin
                $display("FAIL load_timeout: got o_ready=0 expected 1 within 500 cycles");
                $fatal(1, "input never accepted");
            end
        end
        i_valid     = 1'b0;
        last_hs_cyc = hcyc;
    endtask

    task automatic send_frame(input frame_t w, input bit gaps);
        for (int k = 0; k < M; k++) begin
            send_word(w[k], (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        push_model(w);
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    initial begin
        frame_t f;
        int     c;
        int     prev;
        int     base;
        logic [N-1:0]  hd;
        logic [IW-1:0] hi;

        repeat (3) @(negedge clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_busy",  int'(o_busy),  0);
        check("rst_last",  int'(o_last),  0);
        check("rst_data",  int'(o_data),  0);
        check("rst_idx",   int'(o_idx),   0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame with latency checks.
        rdy_mode = 0;
        f = '{4'd3, 4'd9, 4'd1, 4'd7};
        send_frame(f, 1'b0);
        prev = last_hs_cyc;
        for (int j = 0; j < M; j++) begin
            wait_valid(c);
            check(j == 0 ? "first_latency" : "out_to_out", c - prev, N + 1);
            prev = c;
            @(posedge clk); #1;
        end
        wait_idle();
        check("busy_after_frame", int'(o_busy), 0);
        @(posedge clk); #1;

        // Duplicates keep input order.
        f = '{4'd5, 4'd5, 4'd5, 4'd5};
        send_frame(f, 1'b0);
        wait_idle();
        @(posedge clk); #1;

        // All-zero frame, then ready for the next frame.
        f = '{4'd0, 4'd0, 4'd0, 4'd0};
        send_frame(f, 1'b0);
        wait_idle();
        check("ready_after_zero", int'(o_ready), 1);
        @(posedge clk); #1;

        // Backpressure holds the output word steady.
        rdy_manual = 1'b0;
        rdy_mode   = 2;
        f = '{4'd3, 4'd9, 4'd1, 4'd7};
        send_frame(f, 1'b0);
        wait_valid(c);
        hd = o_data;
        hi = o_idx;
        check("bp_first_data", int'(hd), 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid_held", int'(o_valid), 1);
            check("bp_data_held",  int'(o_data),  int'(hd));
            check("bp_idx_held",   int'(o_idx),   int'(hi));
        end
        check("bp_no_pop", exp_q.size(), M);
        rdy_manual = 1'b1;
        wait_idle();
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset during the search pass after two outputs.
        base = n_pops;
        f = '{4'd8, 4'd2, 4'd12, 4'd4};
        send_frame(f, 1'b0);
        for (int k = 0; k < 200 && n_pops < base + 2; k++) begin
            @(posedge clk); #1;
        end
        check("two_pops_before_rst", n_pops - base, 2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_busy",  int'(o_busy),  0);
        check("midrst_ready", int'(o_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        f = '{4'd2, 4'd14, 4'd14, 4'd6};
        send_frame(f, 1'b0);
        wait_idle();
        @(posedge clk); #1;

        // Randomized frames with input gaps and random downstream stalls.
        rdy_mode = 1;
        for (int fr = 0; fr < 1000; fr++) begin
            for (int k = 0; k < M; k++) begin
                f[k] = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 15)) : N'($urandom_range(4, 6));
            end
            send_frame(f, 1'b1);
        end
        wait_idle();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
